// File: rtl/coin_input_ctrl.sv
// -----------------------------------------------------------------------------
// coin_input_ctrl
//
// Purpose:
//   Front-end conditioner that sits directly in front of the vending FSM.
//   The raw coin and cancel push-buttons are synchronised and debounced. Each
//   clean press becomes a single-cycle pulse. The coin-type and drink-select
//   switch banks are synchronised and presented as stable codes. A coin press
//   is rejected when its coin code is "none" or when the FSM reports busy.
//
// Parameters:
//   DB_CYCLES  consecutive disagreeing cycles needed to accept a button change
//   CNT_W      debounce counter width (DB_CYCLES must be < 2**CNT_W)
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   btn_coin_i     raw coin-insert button (asynchronous, active-high)
//   btn_cancel_i   raw cancel button (asynchronous, active-high)
//   sw_coin_i      raw coin-type switches: 00 none, 01 0.5, 10 1.0, 11 5.0
//   sw_drink_i     raw drink-select switches: 01 drink 1, 10 drink 2, else none
//   busy_i         FSM busy; blocks new coins (already synchronous)
//   insert_o       one-cycle coin-accepted pulse
//   coin_val_o     accepted coin code, updated only with insert_o
//   cancel_flag_o  one-cycle cancel pulse
//   drink_op_o     synchronised drink selection, code 11 shown as 00
//   coin_err_o     one-cycle pulse when a coin press is rejected
// -----------------------------------------------------------------------------
module coin_input_ctrl #(
  parameter int DB_CYCLES = 20,
  parameter int CNT_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_coin_i,
  input  logic       btn_cancel_i,
  input  logic [1:0] sw_coin_i,
  input  logic [1:0] sw_drink_i,
  input  logic       busy_i,
  output logic       insert_o,
  output logic [1:0] coin_val_o,
  output logic       cancel_flag_o,
  output logic [1:0] drink_op_o,
  output logic       coin_err_o
);

  // Button index within the packed per-button vectors below.
  localparam int BTN_COIN   = 0;
  localparam int BTN_CANCEL = 1;

  // The level flips on the DB_CYCLES-th consecutive disagreeing cycle. When the
  // counter holds DB_LAST, the current cycle is that final disagreeing cycle.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Outcome of the button events seen in one cycle. Only one outcome can
  // happen, because a cancel press always wins over a coin press.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_CANCEL,
    EV_REJECT,
    EV_ACCEPT
  } coin_event_e;

  // Synchroniser stages. The switch buses are synchronised bit by bit. A
  // switch change caught mid-transition can show one intermediate code for a
  // single cycle. That is acceptable for slow, manually operated switches.
  logic [1:0]            btnMeta_q, btnSync_q;
  logic [1:0]            swCoinMeta_q, swCoinSync_q;
  logic [1:0]            swDrinkMeta_q, swDrinkSync_q;

  // Debounce state for each button. dbPrev_q is the level one cycle ago.
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            db_q, db_d;
  logic [1:0]            dbPrev_q;

  // Registered outputs.
  logic                  insert_q, insert_d;
  logic                  cancel_q, cancel_d;
  logic                  coinErr_q, coinErr_d;
  logic [1:0]            coinVal_q, coinVal_d;
  logic [1:0]            drinkOp_q, drinkOp_d;

  logic                  coinPress, cancelPress;
  coin_event_e           event_d;

  // Two-flop synchronisers for every raw asynchronous input. Reset clears
  // them, so a press in progress must be seen again from scratch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btnMeta_q     <= '0;
      btnSync_q     <= '0;
      swCoinMeta_q  <= '0;
      swCoinSync_q  <= '0;
      swDrinkMeta_q <= '0;
      swDrinkSync_q <= '0;
    end else begin
      btnMeta_q     <= {btn_cancel_i, btn_coin_i};
      btnSync_q     <= btnMeta_q;
      swCoinMeta_q  <= sw_coin_i;
      swCoinSync_q  <= swCoinMeta_q;
      swDrinkMeta_q <= sw_drink_i;
      swDrinkSync_q <= swDrinkMeta_q;
    end
  end

  // Debounce next-state. Any cycle in which the synchronised level agrees with
  // the debounced level restarts the count. The saturation guard is only a
  // safety net: the count is cleared when the level flips, so it normally stops
  // at DB_LAST.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int b = 0; b < 2; b++) begin
      if (btnSync_q[b] == db_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] >= DB_LAST) begin
        db_d[b]  = ~db_q[b];
        cnt_d[b] = '0;
      end else if (cnt_q[b] != CNT_MAX) begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  // Debounce registers. dbPrev_q lags db_q by one cycle for press detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      db_q     <= '0;
      dbPrev_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      dbPrev_q <= db_q;
    end
  end

  // A press is the debounced 0->1 step. A release or a held button produces
  // nothing more, so each pulse below can last only one cycle.
  assign coinPress   = db_q[BTN_COIN]   & ~dbPrev_q[BTN_COIN];
  assign cancelPress = db_q[BTN_CANCEL] & ~dbPrev_q[BTN_CANCEL];

  // Event resolution. Cancel takes priority, and a coin press that lands in the
  // same cycle is silently dropped. busy_i comes from the FSM's own clock
  // domain, so it is used directly without synchronising. The coin code is
  // taken from the synchronised switches in the same cycle as the press.
  always_comb begin
    event_d = EV_NONE;
    if (cancelPress) begin
      event_d = EV_CANCEL;
    end else if (coinPress) begin
      if (busy_i || (swCoinSync_q == 2'b00)) begin
        event_d = EV_REJECT;
      end else begin
        event_d = EV_ACCEPT;
      end
    end
  end

  // Output next-state. coin_val holds its value until the next accepted coin.
  // Drink code 11 is not a valid selection, so it is shown as "none".
  always_comb begin
    insert_d  = 1'b0;
    cancel_d  = 1'b0;
    coinErr_d = 1'b0;
    coinVal_d = coinVal_q;
    case (event_d)
      EV_CANCEL: cancel_d  = 1'b1;
      EV_REJECT: coinErr_d = 1'b1;
      EV_ACCEPT: begin
        insert_d  = 1'b1;
        coinVal_d = swCoinSync_q;
      end
      default: ;
    endcase
    drinkOp_d = (swDrinkSync_q == 2'b11) ? 2'b00 : swDrinkSync_q;
  end

  // Output register stage. Its output is what the FSM sees.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      insert_q  <= 1'b0;
      cancel_q  <= 1'b0;
      coinErr_q <= 1'b0;
      coinVal_q <= 2'b00;
      drinkOp_q <= 2'b00;
    end else begin
      insert_q  <= insert_d;
      cancel_q  <= cancel_d;
      coinErr_q <= coinErr_d;
      coinVal_q <= coinVal_d;
      drinkOp_q <= drinkOp_d;
    end
  end

  assign insert_o      = insert_q;
  assign cancel_flag_o = cancel_q;
  assign coin_err_o    = coinErr_q;
  assign coin_val_o    = coinVal_q;
  assign drink_op_o    = drinkOp_q;

endmodule

// File: tb/tb_coin_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coin_input_ctrl
//
// Directed scenarios followed by a randomised phase. Every clock cycle the DUT
// outputs are compared with a behavioural reference model. The model keeps a
// window of raw input samples. It accepts a new button level once the last
// DB synchronised samples all disagree with the current level.
// -----------------------------------------------------------------------------
module tb_coin_input_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnCoin, btnCancel, busy;
  logic [1:0] swCoin, swDrink;
  logic       insertO, cancelO, coinErrO;
  logic [1:0] coinValO, drinkOpO;

  int compared   = 0;
  int mismatched = 0;

  // Model state: raw input history (index 0 = newest), debounced levels and
  // the outputs expected after the current edge.
  bit         cHist[$];
  bit         xHist[$];
  logic [1:0] scHist[$];
  logic [1:0] sdHist[$];
  bit         mLvlC, mLvlCPrev, mLvlX, mLvlXPrev;
  logic       eInsert, eCancel, eErr;
  logic [1:0] eCoinVal, eDrink;

  // Event counters used by the directed checks.
  int cycleNo = 0;
  int insCnt, canCnt, errCnt;
  int lastIns, lastCan;

  coin_input_ctrl #(.DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .btn_coin_i   (btnCoin),
    .btn_cancel_i (btnCancel),
    .sw_coin_i    (swCoin),
    .sw_drink_i   (swDrink),
    .busy_i       (busy),
    .insert_o     (insertO),
    .coin_val_o   (coinValO),
    .cancel_flag_o(cancelO),
    .drink_op_o   (drinkOpO),
    .coin_err_o   (coinErrO)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    cHist.delete(); xHist.delete(); scHist.delete(); sdHist.delete();
    for (int i = 0; i < DB + 2; i++) begin
      cHist.push_front(1'b0);
      xHist.push_front(1'b0);
      scHist.push_front(2'b00);
      sdHist.push_front(2'b00);
    end
    mLvlC = 0; mLvlCPrev = 0; mLvlX = 0; mLvlXPrev = 0;
    eInsert = 0; eCancel = 0; eErr = 0; eCoinVal = 2'b00; eDrink = 2'b00;
  endtask

  // One clock edge of the model. Index 1 of each history is the sample that
  // has just emerged from the two-flop synchroniser.
  task automatic modelEdge();
    bit cEvt, xEvt, flipC, flipX;
    cEvt  = mLvlC & ~mLvlCPrev;
    xEvt  = mLvlX & ~mLvlXPrev;
    flipC = 1; flipX = 1;
    for (int i = 1; i <= DB; i++) begin
      if (cHist[i] == mLvlC) flipC = 0;
      if (xHist[i] == mLvlX) flipX = 0;
    end
    mLvlCPrev = mLvlC;
    mLvlXPrev = mLvlX;
    if (flipC) mLvlC = ~mLvlC;
    if (flipX) mLvlX = ~mLvlX;
    eInsert = 0; eErr = 0; eCancel = xEvt;
    if (!xEvt && cEvt) begin
      if (busy || scHist[1] == 2'b00) eErr = 1;
      else begin
        eInsert  = 1;
        eCoinVal = scHist[1];
      end
    end
    eDrink = (sdHist[1] == 2'b11) ? 2'b00 : sdHist[1];
    cHist.push_front(btnCoin);   void'(cHist.pop_back());
    xHist.push_front(btnCancel); void'(xHist.pop_back());
    scHist.push_front(swCoin);   void'(scHist.pop_back());
    sdHist.push_front(swDrink);  void'(sdHist.pop_back());
  endtask

  task automatic checkAll();
    checkOutput("insert",      {31'd0, insertO},  {31'd0, eInsert});
    checkOutput("cancel_flag", {31'd0, cancelO},  {31'd0, eCancel});
    checkOutput("coin_err",    {31'd0, coinErrO}, {31'd0, eErr});
    checkOutput("coin_val",    {30'd0, coinValO}, {30'd0, eCoinVal});
    checkOutput("drink_op",    {30'd0, drinkOpO}, {30'd0, eDrink});
  endtask

  // Advance one clock and compare #1 after the edge.
  task automatic step();
    @(posedge clk);
    if (!rst) modelEdge();
    #1;
    cycleNo++;
    checkAll();
    if (insertO === 1'b1) begin insCnt++; lastIns = cycleNo; end
    if (cancelO === 1'b1) begin canCnt++; lastCan = cycleNo; end
    if (coinErrO === 1'b1) errCnt++;
  endtask

  task automatic applyStimulus(input logic c, input logic x, input logic [1:0] sc,
                               input logic [1:0] sd, input logic b, input int n);
    btnCoin = c; btnCancel = x; swCoin = sc; swDrink = sd; busy = b;
    repeat (n) step();
  endtask

  task automatic clearCounts();
    insCnt = 0; canCnt = 0; errCnt = 0; lastIns = -100; lastCan = -100;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    btnCoin = 0; btnCancel = 0; swCoin = 0; swDrink = 0; busy = 0;
    modelReset();
    clearCounts();
    repeat (3) step();
    rst = 1'b0;
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 4);

    // Held press: exactly one insert, seven edges after the first sample.
    clearCounts();
    s = cycleNo;
    applyStimulus(1, 0, 2'b01, 2'b00, 0, 20);
    applyStimulus(0, 0, 2'b01, 2'b00, 0, 10);
    checkOutput("t1 inserts", insCnt, 1);
    checkOutput("t1 latency", lastIns - s, 7);
    checkOutput("t1 coin_val", {30'd0, coinValO}, 32'h1);
    checkOutput("t1 errors", errCnt, 0);

    // Bounce shorter than the debounce window is ignored.
    clearCounts();
    applyStimulus(1, 0, 2'b10, 2'b00, 0, 3);
    applyStimulus(0, 0, 2'b10, 2'b00, 0, 1);
    applyStimulus(1, 0, 2'b10, 2'b00, 0, 3);
    applyStimulus(0, 0, 2'b10, 2'b00, 0, 8);
    checkOutput("t2 bounce inserts", insCnt, 0);
    checkOutput("t2 bounce errors", errCnt, 0);
    applyStimulus(1, 0, 2'b10, 2'b00, 0, 10);
    applyStimulus(0, 0, 2'b10, 2'b00, 0, 10);
    checkOutput("t2 inserts", insCnt, 1);
    checkOutput("t2 coin_val", {30'd0, coinValO}, 32'h2);

    // Rejections: empty coin code, then busy FSM.
    clearCounts();
    applyStimulus(1, 0, 2'b00, 2'b00, 0, 10);
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 10);
    checkOutput("t3 code00 errors", errCnt, 1);
    checkOutput("t3 code00 coin_val", {30'd0, coinValO}, 32'h2);
    applyStimulus(1, 0, 2'b11, 2'b00, 1, 10);
    applyStimulus(0, 0, 2'b11, 2'b00, 1, 10);
    checkOutput("t3 busy errors", errCnt, 2);
    checkOutput("t3 inserts", insCnt, 0);

    // Simultaneous coin and cancel, then cancel while busy.
    clearCounts();
    s = cycleNo;
    applyStimulus(1, 1, 2'b01, 2'b00, 0, 12);
    applyStimulus(0, 0, 2'b01, 2'b00, 0, 10);
    checkOutput("t4 cancels", canCnt, 1);
    checkOutput("t4 cancel latency", lastCan - s, 7);
    checkOutput("t4 inserts", insCnt, 0);
    checkOutput("t4 errors", errCnt, 0);
    applyStimulus(0, 1, 2'b01, 2'b00, 1, 10);
    applyStimulus(0, 0, 2'b01, 2'b00, 1, 10);
    checkOutput("t4 busy cancels", canCnt, 2);

    // Drink selection path with a three-edge latency.
    applyStimulus(0, 0, 2'b01, 2'b01, 0, 3);
    checkOutput("t5 drink 01", {30'd0, drinkOpO}, 32'h1);
    applyStimulus(0, 0, 2'b01, 2'b11, 0, 3);
    checkOutput("t5 drink 11", {30'd0, drinkOpO}, 32'h0);
    applyStimulus(0, 0, 2'b01, 2'b10, 0, 2);
    checkOutput("t5 drink early", {30'd0, drinkOpO}, 32'h0);
    applyStimulus(0, 0, 2'b01, 2'b10, 0, 1);
    checkOutput("t5 drink 10", {30'd0, drinkOpO}, 32'h2);

    // Reset in the middle of a debounce (count = 2) discards the press.
    clearCounts();
    applyStimulus(1, 0, 2'b01, 2'b10, 0, 4);
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    checkOutput("t6 reset coin_val", {30'd0, coinValO}, 32'h0);
    repeat (2) step();
    rst = 1'b0;
    s = cycleNo;
    applyStimulus(1, 0, 2'b01, 2'b10, 0, 12);
    applyStimulus(0, 0, 2'b01, 2'b10, 0, 5);
    checkOutput("t6 inserts", insCnt, 1);
    checkOutput("t6 latency", lastIns - s, 7);

    // Randomised phase, checked cycle by cycle against the model.
    for (int seg = 0; seg < 60; seg++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) == 0), $urandom_range(1, 12));
    end
    applyStimulus(0, 0, 2'b00, 2'b00, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
